// File: rtl/imu_spi_seq_pkg.sv
// imu_pkg: sequencer states, gyro read commands and default configuration words
package imu_pkg;
    typedef enum logic [2:0] {PWR_WAIT, CFG0, CFG1, CFG2, IDLE, RD_L, RD_H} state_t;
    localparam logic [15:0] YAWL_RD  = 16'hA600;
    localparam logic [15:0] YAWH_RD  = 16'hA700;
    localparam logic [15:0] CFG0_DEF = 16'h0D02;
    localparam logic [15:0] CFG1_DEF = 16'h1160;
    localparam logic [15:0] CFG2_DEF = 16'h1440;
endpackage

// File: rtl/imu_spi_seq_if.sv
// imu_spi_seq_if: command/response link between the sequencer (master) and the SPI monarch (slave)
//   snd  - start transaction pulse      cmd  - 16-bit command, held while open
//   done - transaction complete level   resp - response, low byte meaningful
interface imu_spi_seq_if;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;
    modport master (output snd, cmd, input done, resp);
    modport slave  (input snd, cmd, output done, resp);
endinterface

// File: rtl/imu_spi_seq_sync2.sv
// sync2: two-flop synchroniser with asynchronous active-low reset to 0
//   clk, rst_n - clock and reset   i_d - asynchronous input   o_q - synchronised output
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= '0;
        else        r_q <= {r_q[0], i_d};
    assign o_q = r_q[1];
endmodule

// File: rtl/imu_spi_seq.sv
// imu_spi_seq: gyro power-up wait, three config writes, then yaw-rate reads on each data-ready
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_int       - gyro data-ready (asynchronous)
//   spi         - master side of the SPI monarch link
//   o_yaw_rt    - signed yaw rate {high byte, low byte}
//   o_vld       - one-cycle strobe when o_yaw_rt updates
//   o_init_done - configuration complete, sticky until reset
module imu_spi_seq import imu_pkg::*; #(
    parameter int          STARTUP_W = 16,
    parameter logic [15:0] CFG0      = CFG0_DEF,
    parameter logic [15:0] CFG1      = CFG1_DEF,
    parameter logic [15:0] CFG2      = CFG2_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_int,
    imu_spi_seq_if.master        spi,
    output logic [15:0]          o_yaw_rt,
    output logic                 o_vld,
    output logic                 o_init_done
);
    state_t                 r_state, w_state;
    logic [STARTUP_W-1:0]   r_cnt, w_cnt;
    logic                   r_snd, w_snd, r_vld, w_vld, r_init, w_init;
    logic [15:0]            r_cmd, w_cmd, r_yaw, w_yaw;
    logic [7:0]             r_yawl, w_yawl;
    logic                   w_int_s, w_go, w_unused;
    sync2 u_sync (.clk(clk), .rst_n(rst_n), .i_d(i_int), .o_q(w_int_s));
    // done is still high from the previous transaction in the cycle snd is out
    assign w_go     = spi.done && !r_snd;
    assign w_unused = ^spi.resp[15:8];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= PWR_WAIT;
            r_cnt   <= '0;
            r_snd   <= 1'b0;
            r_cmd   <= '0;
            r_yawl  <= '0;
            r_yaw   <= '0;
            r_vld   <= 1'b0;
            r_init  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_snd   <= w_snd;
            r_cmd   <= w_cmd;
            r_yawl  <= w_yawl;
            r_yaw   <= w_yaw;
            r_vld   <= w_vld;
            r_init  <= w_init;
        end
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_snd   = 1'b0;
        w_cmd   = r_cmd;
        w_yawl  = r_yawl;
        w_yaw   = r_yaw;
        w_vld   = 1'b0;
        w_init  = r_init;
        case (r_state)
            PWR_WAIT: begin
                w_cnt = r_cnt + 1'b1;
                if (&r_cnt) begin w_snd = 1'b1; w_cmd = CFG0; w_state = imu_pkg::CFG0; end
            end
            imu_pkg::CFG0: if (w_go) begin w_snd = 1'b1; w_cmd = CFG1; w_state = imu_pkg::CFG1; end
            imu_pkg::CFG1: if (w_go) begin w_snd = 1'b1; w_cmd = CFG2; w_state = imu_pkg::CFG2; end
            imu_pkg::CFG2: if (w_go) begin w_init = 1'b1; w_state = IDLE; end
            IDLE:     if (w_int_s) begin w_snd = 1'b1; w_cmd = YAWL_RD; w_state = RD_L; end
            RD_L:     if (w_go) begin w_yawl = spi.resp[7:0]; w_snd = 1'b1; w_cmd = YAWH_RD; w_state = RD_H; end
            RD_H:     if (w_go) begin w_yaw = {spi.resp[7:0], r_yawl}; w_vld = 1'b1; w_state = IDLE; end
            default:  w_state = PWR_WAIT;
        endcase
    end
    assign spi.snd     = r_snd;
    assign spi.cmd     = r_cmd;
    assign o_yaw_rt    = r_yaw;
    assign o_vld       = r_vld;
    assign o_init_done = r_init;
endmodule

// File: tb/tb_imu_spi_seq.sv
// tb_imu_spi_seq: SPI monarch + gyro model, per-cycle behavioural reference and directed/random scenarios
module tb_imu_spi_seq;
    import imu_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0, int_hold = 1'b0, int_l, vld, init_done;
    logic [15:0] yaw_rt, g_yaw = 16'h0;
    int          int_req = 0, int_srv = 0, m_cnt = 0;
    int          checks = 0, errors = 0;
    always #5 clk = ~clk;
    imu_spi_seq_if spi();
    assign int_l = int_hold | (int_req != int_srv);
    imu_spi_seq #(.STARTUP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_int(int_l), .spi(spi),
        .o_yaw_rt(yaw_rt), .o_vld(vld), .o_init_done(init_done)
    );
    // monarch: done drops the cycle after snd, returns 40 clk after snd; gyro clears INT when the high byte is read
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            spi.done <= 1'b1;
            spi.resp <= '0;
            m_cnt    <= 0;
        end else if (spi.snd) begin
            spi.done <= 1'b0;
            spi.resp <= 16'($urandom);
            m_cnt    <= 39;
            if (spi.cmd == YAWH_RD) int_srv <= int_req;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                spi.done <= 1'b1;
                spi.resp <= {8'($urandom), spi.cmd == YAWL_RD ? g_yaw[7:0] :
                                           spi.cmd == YAWH_RD ? g_yaw[15:8] : 8'($urandom)};
            end
        end
    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // n-th command after reset: three config words, then alternating low/high reads
    function automatic logic [15:0] cmd_for(int n);
        return n == 0 ? CFG0_DEF : n == 1 ? CFG1_DEF : n == 2 ? CFG2_DEF : n[0] ? YAWL_RD : YAWH_RD;
    endfunction
    int          cyc = 0, nsnd = 0, nvld = 0, b2b = 0;
    int          first_snd_cyc = -1, init_cyc = -1, first_rd_cyc = -1, last_vld_cyc = -10;
    bit          open = 0, idle = 0, e_snd = 0, e_vld = 0, e_init = 0, i1 = 0, i2 = 0;
    logic [15:0] e_cmd = 0, e_yaw = 0, open_cmd = 0;
    logic [7:0]  lo = 0;
    logic [15:0] cmdq[$];
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_snd", 16'(spi.snd), 16'h0);
            chk("rst_cmd", spi.cmd, 16'h0);
            chk("rst_vld", 16'(vld), 16'h0);
            chk("rst_yaw", yaw_rt, 16'h0);
            chk("rst_init", 16'(init_done), 16'h0);
            cyc = 0; nsnd = 0; open = 0; idle = 0; e_snd = 0; e_vld = 0; e_init = 0; e_yaw = 0;
            i1 = 0; i2 = 0; first_snd_cyc = -1; init_cyc = -1; first_rd_cyc = -1; last_vld_cyc = -10;
            cmdq.delete();
        end else begin
            chk("snd", 16'(spi.snd), 16'(e_snd));
            if (spi.snd) chk("cmd", spi.cmd, e_cmd);
            chk("vld", 16'(vld), 16'(e_vld));
            chk("yaw_rt", yaw_rt, e_yaw);
            chk("init_done", 16'(init_done), 16'(e_init));
            if (init_done && init_cyc < 0) init_cyc = cyc;
            if (vld) begin nvld++; last_vld_cyc = cyc; end
            e_snd = 0;
            e_vld = 0;
            if (cyc == 15) begin e_snd = 1; e_cmd = cmd_for(0); end
            if (idle && i2) begin e_snd = 1; e_cmd = YAWL_RD; idle = 0; end
            if (spi.snd) begin
                checks++;
                assert (!open) else begin errors++; $display("FAIL snd_while_open: cmd %h", spi.cmd); end
                open = 1;
                open_cmd = spi.cmd;
                cmdq.push_back(spi.cmd);
                if (first_snd_cyc < 0) first_snd_cyc = cyc;
                if (spi.cmd == YAWL_RD && first_rd_cyc < 0) first_rd_cyc = cyc;
                if (spi.cmd == YAWL_RD && last_vld_cyc == cyc - 1) b2b++;
                nsnd++;
            end else if (open) begin
                checks++;
                assert (spi.cmd == open_cmd) else begin
                    errors++;
                    $display("FAIL cmd_stable: got %h expected %h", spi.cmd, open_cmd);
                end
                if (spi.done) begin
                    open = 0;
                    if (nsnd < 3) begin e_snd = 1; e_cmd = cmd_for(nsnd); end
                    else if (nsnd == 3) begin e_init = 1; idle = 1; end
                    else if (cmd_for(nsnd - 1) == YAWL_RD) begin lo = spi.resp[7:0]; e_snd = 1; e_cmd = YAWH_RD; end
                    else begin e_vld = 1; e_yaw = {spi.resp[7:0], lo}; idle = 1; end
                end
            end
            i2 = i1;
            i1 = int_l;
            cyc++;
        end
    end
    task automatic wait_vld(int n, string name);
        for (int i = 0; i < 400 && nvld < n; i++) @(posedge clk);
        #2;
        if (nvld < n) chk({name, "_timeout"}, 16'(nvld), 16'(n));
    endtask
    task automatic wait_init();
        for (int i = 0; i < 400 && !init_done; i++) @(posedge clk);
        #2;
        chk("init_reached", 16'(init_done), 16'h1);
    endtask
    task automatic check_init_seq();
        chk("first_snd_cyc", 16'(first_snd_cyc), 16'd16);
        chk("cfg0_cmd", cmdq.size() > 0 ? cmdq[0] : 16'hxxxx, 16'h0D02);
        chk("cfg1_cmd", cmdq.size() > 1 ? cmdq[1] : 16'hxxxx, 16'h1160);
        chk("cfg2_cmd", cmdq.size() > 2 ? cmdq[2] : 16'hxxxx, 16'h1440);
    endtask
    initial begin
        int n0;
        int_hold = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_init();
        check_init_seq();
        wait_vld(2, "held_int");
        int_hold = 1'b0;
        chk("rd_after_init", 16'(first_rd_cyc - init_cyc >= 1 && first_rd_cyc - init_cyc <= 3), 16'h1);
        chk("back_to_back", 16'(b2b >= 1), 16'h1);
        repeat (200) @(posedge clk);
        #2;
        g_yaw = 16'hFE37;
        n0 = nvld;
        int_req++;
        wait_vld(n0 + 1, "yaw_fe37");
        chk("yaw_fe37", yaw_rt, 16'hFE37);
        repeat (100) @(posedge clk);
        #2;
        chk("single_vld", 16'(nvld), 16'(n0 + 1));
        for (int k = 0; k < 8; k++) begin
            g_yaw = 16'($urandom);
            repeat ($urandom_range(1, 30)) @(posedge clk);
            #2;
            n0 = nvld;
            int_req++;
            wait_vld(n0 + 1, "rand_rd");
            chk("rand_yaw", yaw_rt, g_yaw);
        end
        g_yaw = 16'h5AA5;
        n0 = nvld;
        int_req++;
        for (int i = 0; i < 300 && !(open && open_cmd == YAWH_RD); i++) @(posedge clk);
        chk("reached_rd_h", open_cmd, YAWH_RD);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_snd", 16'(spi.snd), 16'h0);
        chk("arst_vld", 16'(vld), 16'h0);
        chk("arst_init", 16'(init_done), 16'h0);
        chk("arst_yaw", yaw_rt, 16'h0);
        chk("arst_cmd", spi.cmd, 16'h0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_init();
        check_init_seq();
        repeat (60) @(posedge clk);
        #2;
        chk("no_partial_yaw", 16'(nvld), 16'(n0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
